cla_add_pipe: RTL
=================

// Module: cla_add_pipe
// PURPOSE
//  Two-stage pipelined WIDTH-bit adder/subtractor built on the team's 4-bit group-lookahead
//  scheme. Stage 1 forms per-bit and per-nibble generate/propagate terms and registers them.
//  Stage 2 resolves the nibble carries from those terms and forms sum/flags.
//  It is the consumer end of the g/p carry interface; used by blitter/GPU address and data paths.
// PARAMETERS
//  WIDTH   32   operand width in bits; must be a multiple of 4 (elaboration error otherwise)
// PORTS
//  sys_clk    in   1      system clock, all state on rising edge
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      operand beat present
//  in_ready   out  1      block accepts beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      1: A-B (B inverted, carry-in forced 1); 0: A+B+cin
//  cin        in   1      carry-in; ignored when sub=1
//  out_valid  out  1      result beat present
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of MSB (for sub: 1 = no borrow)
//  ovf        out  1      signed two's-complement overflow
// BEHAVIOUR
//  - Reset (async assert, sync-safe release): s1_valid=0, s2_valid=0, out_valid=0, sum=0,
//    cout=0, ovf=0; in_ready=1 one cycle after reset deasserts.
//  - Stage 1, on accept: bb = sub ? ~b : b; c0 = sub ? 1 : cin.
//    Per bit: p=a^bb, g=a&bb. Per nibble k: G = g3|p3g2|p3p2g1|p3p2p1g0, P = p0&p1&p2&p3.
//    Register p[], g[], G[], P[], c0, a[MSB], bb[MSB].
//  - Stage 2: nibble carry C[k+1] = G[k] | P[k]&C[k], C[0]=c0 (lookahead across nibbles).
//    Intra-nibble carries from g/p/C[k]; sum = p ^ carries.
//    cout = C[WIDTH/4]; ovf = (a_msb==bb_msb) & (sum_msb!=a_msb).
//  - Handshake: beat transfers on valid&ready at each boundary.
//    s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv.
//    in_ready = s1_adv (combinational from out_ready; no bubbles at full throughput).
//  - Latency: accepted beat appears on out_valid exactly 2 cycles later if out_ready held 1.
//    Throughput 1 beat/cycle.
//  - Stall: out_ready=0 with out_valid=1 holds sum/cout/ovf/out_valid stable.
//    Stage 1 holds if occupied. Both stages full -> in_ready=0. Max 2 beats in flight.
//  - Simultaneous: full pipe + out_ready=1 + in_valid=1 -> all stages shift, new beat
//    accepted, none lost.
//  - in_valid=0 while advancing -> bubble; stage valid cleared, data regs may hold stale.
//  - Outputs only change when out_valid=0 or the current beat is consumed.
//  - Reset mid-operation discards all in-flight beats; no result emitted for them.
// CONFIGURATION
//  - CLA_SAT_EN defined: extra input sat (1 bit, registered with beat).
//    When sat=1 and ovf: sum = a_msb ? {1'b1,{WIDTH-1{1'b0}}} : {1'b0,{WIDTH-1{1'b1}}}.
//    ovf still reports 1. Clamp is applied in stage 2; latency unchanged.
//  - CLA_SAT_EN undefined: no sat port; sum is always modular WIDTH-bit result.
// TESTING  (WIDTH=32)
//  1. a=0xFFFFFFFF b=0x00000001 sub=0 cin=0 -> 2 clk later sum=0, cout=1, ovf=0
//     (full ripple through all 8 nibbles).
//  2. a=0x7FFFFFFF b=1 sub=0 -> sum=0x80000000 ovf=1.
//     With CLA_SAT_EN and sat=1 -> sum=0x7FFFFFFF ovf=1.
//  3. a=5 b=7 sub=1 -> sum=0xFFFFFFFE cout=0 ovf=0; a=7 b=5 sub=1 -> sum=2 cout=1.
//  4. Stream 16 beats, out_ready=1 constant -> 16 results in order, one per cycle,
//     first 2 clk after first accept.
//     Hold out_ready=0 4 cycles mid-stream -> in_ready=0 after 2 beats, no loss or dup.
//  5. Pipe full, assert reset for 1 cycle -> out_valid=0 immediately, sum=0;
//     in-flight beats never appear.
//  6. 10k random a/b/sub/cin with random in_valid/out_ready -> every result matches
//     reference model {cout,sum}=a+(sub?~b:b)+(sub?1:cin).

Source files
------------

// File: rtl/cla_add_pipe.sv
// cla_add_pipe: two-stage pipelined WIDTH-bit adder/subtractor using 4-bit
// group lookahead. Stage 1 registers bit/nibble generate-propagate terms,
// stage 2 resolves nibble carries and registers sum/cout/ovf.
// Optional feature macro: CLA_SAT_EN adds a 'sat' input that clamps the
// result to the signed extreme on two's-complement overflow.
module cla_add_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
`ifdef CLA_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_chk
    $error("cla_add_pipe: WIDTH must be a non-zero multiple of 4");
  end

  // ---------------- handshake ----------------
  logic r_init;
  logic r_s1_valid;
  logic r_s2_valid;
  logic w_s1_adv;
  logic w_s2_adv;
  logic w_in_fire;

  assign w_s2_adv  = !r_s2_valid | out_ready;
  assign w_s1_adv  = !r_s1_valid | w_s2_adv;
  // r_init keeps the input closed for the first cycle after reset release
  assign in_ready  = r_init & w_s1_adv;
  assign w_in_fire = in_valid & in_ready;
  assign out_valid = r_s2_valid;

  // Reset-release qualifier: opens in_ready one clock after reset drops
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) r_init <= 1'b0;
    else       r_init <= 1'b1;
  end

  // ---------------- stage 1: g/p terms ----------------
  logic [WIDTH-1:0] w_bb;
  logic             w_c0;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [NIB-1:0]   w_G;
  logic [NIB-1:0]   w_P;

  assign w_bb = sub ? ~b : b;
  assign w_c0 = sub | cin;
  assign w_p  = a ^ w_bb;
  assign w_g  = a & w_bb;

  for (genvar k = 0; k < NIB; k++) begin : g_nib
    assign w_G[k] = w_g[4*k+3]
                  | (w_p[4*k+3] & w_g[4*k+2])
                  | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                  | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
    assign w_P[k] = &w_p[4*k +: 4];
  end

  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_g;
  logic [NIB-1:0]   r_G;
  logic [NIB-1:0]   r_P;
  logic             r_c0;
  logic             r_a_msb;
  logic             r_bb_msb;
`ifdef CLA_SAT_EN
  logic             r_sat;
`endif

  // Stage 1 register: capture g/p terms of an accepted beat, bubble otherwise
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_p        <= '0;
      r_g        <= '0;
      r_G        <= '0;
      r_P        <= '0;
      r_c0       <= 1'b0;
      r_a_msb    <= 1'b0;
      r_bb_msb   <= 1'b0;
`ifdef CLA_SAT_EN
      r_sat      <= 1'b0;
`endif
    end else if (w_s1_adv) begin
      r_s1_valid <= w_in_fire;
      if (w_in_fire) begin
        r_p      <= w_p;
        r_g      <= w_g;
        r_G      <= w_G;
        r_P      <= w_P;
        r_c0     <= w_c0;
        r_a_msb  <= a[WIDTH-1];
        r_bb_msb <= w_bb[WIDTH-1];
`ifdef CLA_SAT_EN
        r_sat    <= sat;
`endif
      end
    end
  end

  // ---------------- stage 2: carry resolve ----------------
  logic [WIDTH-1:0] w_sum_raw;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  // Nibble carries by lookahead, then intra-nibble carries from each C[k]
  always_comb begin
    logic [NIB:0]     c_n;
    logic [WIDTH-1:0] cy;
    c_n    = '0;
    cy     = '0;
    c_n[0] = r_c0;
    for (int k = 0; k < NIB; k++)
      c_n[k+1] = r_G[k] | (r_P[k] & c_n[k]);
    for (int k = 0; k < NIB; k++) begin
      cy[4*k] = c_n[k];
      for (int j = 1; j < 4; j++)
        cy[4*k+j] = r_g[4*k+j-1] | (r_p[4*k+j-1] & cy[4*k+j-1]);
    end
    w_sum_raw = r_p ^ cy;
    w_cout    = c_n[NIB];
  end

  assign w_ovf = (r_a_msb == r_bb_msb) & (w_sum_raw[WIDTH-1] != r_a_msb);

`ifdef CLA_SAT_EN
  // Clamp toward the sign of A: negative overflow -> min, positive -> max
  assign w_sum = (r_sat & w_ovf)
               ? (r_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
               : w_sum_raw;
`else
  assign w_sum = w_sum_raw;
`endif

  // Stage 2 register: outputs move only when empty or the current beat leaves
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      sum        <= '0;
      cout       <= 1'b0;
      ovf        <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        sum  <= w_sum;
        cout <= w_cout;
        ovf  <= w_ovf;
      end
    end
  end

endmodule
